text_banner_renderer: RTL and testbench
=======================================

// Module: text_banner_renderer
// PURPOSE
//  Parametrised successor to the fixed-word overlay generators. Holds a writable LINES x COLS grid of 5-bit letter codes.
//  Maps the VGA scan position (row, col) to a letter code plus a pixel index inside that glyph's GLYPH x GLYPH sprite.
//  Feeds the shared letter-sprite ROM/colour mux, so game screens set their text at runtime instead of via per-message modules.
// PARAMETERS
//  GLYPH     50   glyph cell edge in pixels; GLYPH*GLYPH <= 8192
//  ORIGIN_X  170  column of grid's left edge
//  ORIGIN_Y  190  row of grid's top edge
//  COLS      4    characters per line
//  LINES     3    text lines; DEPTH = COLS*LINES, AW = clog2(DEPTH)
//  BLINK_FRAMES 30  frames per blink half-period (used only with TEXT_BLINK_EN)
// PORTS
//  clk        in   1   pixel clock
//  reset      in   1   synchronous, active-high
//  row        in   9   current scan row
//  col        in   10  current scan column
//  msg_we     in   1   write strobe for grid buffer
//  msg_addr   in   AW  grid address = line*COLS + char
//  msg_data   in   5   letter code: 0=A..25=Z, 31=blank
//  clear_req  in   1   pulse: fill whole grid with blank
//  frame_tick in   1   one-cycle pulse per frame (blink timebase)
//  busy       out  1   clear sequence in progress
//  letter     out  5   letter code for the pixel (registered)
//  pixel      out  13  sprite index = y_in_cell*GLYPH + x_in_cell (registered)
//  valid      out  1   pixel lies in a non-blank grid cell (registered)
// BEHAVIOUR
//  - Reset: letter=31, pixel=0, valid=0, busy=1, FSM=CLEAR, clear pointer=0, blink phase=on, frame count=0.
//  - FSM IDLE/CLEAR:
//    - CLEAR writes 31 to address ptr each cycle, ptr++.
//    - After writing DEPTH-1 -> IDLE, busy=0 next cycle. Post-reset clear takes DEPTH cycles.
//    - IDLE + clear_req -> CLEAR, ptr=0, busy=1 next cycle.
//    - clear_req while CLEAR: ignored, no restart.
//    - Reset mid-clear restarts the clear from address 0.
//  - Writes:
//    - msg_we in IDLE with msg_addr<DEPTH writes msg_data. Dropped if msg_addr>=DEPTH, FSM=CLEAR, or clear_req in same cycle (clear wins).
//    - A write is visible to lookups issued the following cycle. A same-cycle read of that address returns old data.
//  - Lookup pipeline, latency 2 cycles (inputs at edge N -> outputs valid after edge N+2):
//    - Stage 1 computes rx=col-ORIGIN_X, ry=row-ORIGIN_Y.
//    - in_grid = col>=ORIGIN_X && col<ORIGIN_X+COLS*GLYPH && row>=ORIGIN_Y && row<ORIGIN_Y+LINES*GLYPH.
//    - Cell = (ry/GLYPH, rx/GLYPH); addr = line*COLS+char.
//    - Stage 2 registers letter=buf[addr], pixel=(ry%GLYPH)*GLYPH+(rx%GLYPH), valid=in_grid && letter!=31.
//    - Divide/modulo results must equal exact integer arithmetic at every in-grid position; any implementation (counters, constant multiply) is allowed.
//    - Outside grid: letter=31, pixel=0, valid=0.
//    - During CLEAR, lookups continue; entries not yet cleared return their old contents.
//  - Pixel index arithmetic is 13-bit unsigned; no wrap for legal GLYPH.
// CONFIGURATION
//  TEXT_BLINK_EN defined:
//    - Counter counts frame_tick pulses; on reaching BLINK_FRAMES-1 it wraps to 0 and toggles blink phase.
//    - While phase=off, valid is forced 0; letter and pixel are unchanged.
//    - clear_req resets counter and phase=on.
//  TEXT_BLINK_EN undefined: frame_tick ignored, no counter logic, valid never masked.
// TESTING (defaults GLYPH=50, ORIGIN 170/190, COLS=4, LINES=3)
//  1. reset 1 cycle -> busy=1 for 12 cycles then 0. Any in-grid scan -> letter=31, valid=0.
//  2. write addr0..3 = 19,8,12,4; scan row=190,col=170 -> 2 cycles later letter=19,pixel=0,valid=1. row=239,col=219 -> pixel=2499. col=320 -> letter=4.
//  3. write addr6=18; scan row=240,col=270 -> letter=18,pixel=0. row=265,col=283 -> pixel=25*50+13=1263.
//  4. row=189,col=170 / row=340,col=200 / col=370 -> letter=31,pixel=0,valid=0. msg_addr=12 write -> grid unchanged.
//  5. clear_req with msg_we(addr0=7) same cycle -> write dropped, busy 12 cycles, all cells 31. clear_req mid-clear -> completes at original count.
//  6. TEXT_BLINK_EN: 30 frame_ticks -> valid drops to 0 on in-grid letter. 30 more -> valid returns to 1. Without macro: valid stays 1.

Source files
------------

// File: rtl/text_banner_renderer.sv
// Runtime-writable LINES x COLS letter grid mapped onto the scan position; TEXT_BLINK_EN adds frame-based blinking.
// Lookup latency 2 cycles; no backpressure (one lookup per pixel clock), grid writes dropped while clearing.
module text_banner_renderer #(
    parameter int GLYPH        = 50,
    parameter int ORIGIN_X     = 170,
    parameter int ORIGIN_Y     = 190,
    parameter int COLS         = 4,
    parameter int LINES        = 3,
    parameter int BLINK_FRAMES = 30,
    localparam int DEPTH       = COLS * LINES,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [8:0]    row,
    input  logic [9:0]    col,
    input  logic          msg_we,
    input  logic [AW-1:0] msg_addr,
    input  logic [4:0]    msg_data,
    input  logic          clear_req,
    input  logic          frame_tick,
    output logic          busy,
    output logic [4:0]    letter,
    output logic [12:0]   pixel,
    output logic          valid
);
    localparam int X_END = ORIGIN_X + COLS * GLYPH;
    localparam int Y_END = ORIGIN_Y + LINES * GLYPH;
    localparam logic [4:0] BLANK = 5'd31;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state;
    logic [AW-1:0] ptr;
    logic [4:0]    mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (ptr == AW'(DEPTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + AW'(1);
                    end
                end
                default: begin
                    if (clear_req) begin
                        state <= CLEAR;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // A pending clear beats a host write landing in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR)
                mem[ptr] <= BLANK;
            else if (msg_we && !clear_req && (32'(msg_addr) < DEPTH))
                mem[msg_addr] <= msg_data;
        end
    end

    logic [31:0] col_w, row_w, rx, ry, cx, cy, px, py;
    logic        in_grid;

    always_comb begin
        col_w   = 32'(col);
        row_w   = 32'(row);
        rx      = col_w - ORIGIN_X;
        ry      = row_w - ORIGIN_Y;
        cx      = rx / GLYPH;
        cy      = ry / GLYPH;
        px      = rx % GLYPH;
        py      = ry % GLYPH;
        in_grid = (col_w >= ORIGIN_X) && (col_w < X_END) &&
                  (row_w >= ORIGIN_Y) && (row_w < Y_END);
    end

    logic        s1_in;
    logic [4:0]  s1_letter;
    logic [12:0] s1_pixel;

    // Grid is read in stage 1 so a write is seen by the next cycle's lookup, not the same one.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_in     <= 1'b0;
            s1_letter <= BLANK;
            s1_pixel  <= '0;
        end else begin
            s1_in     <= in_grid;
            s1_letter <= in_grid ? mem[AW'(cy * COLS + cx)] : BLANK;
            s1_pixel  <= in_grid ? 13'(py * GLYPH + px) : 13'd0;
        end
    end

    logic blink_on;

`ifdef TEXT_BLINK_EN
    localparam int CW = $clog2(BLINK_FRAMES + 1);
    logic [CW-1:0] blink_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear_req) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + CW'(1);
            end
        end
    end
`else
    logic unused_blink;
    assign unused_blink = frame_tick ^ (BLINK_FRAMES == 0);
    assign blink_on     = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            letter <= BLANK;
            pixel  <= '0;
            valid  <= 1'b0;
        end else begin
            letter <= s1_letter;
            pixel  <= s1_pixel;
            valid  <= s1_in && (s1_letter != BLANK) && blink_on;
        end
    end
endmodule

// File: tb/tb_text_banner_renderer.sv
// Directed bench for text_banner_renderer: scan expectations are queued at drive time and popped at output time.
module tb_text_banner_renderer;
    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  row;
    logic [9:0]  col;
    logic        msg_we;
    logic [3:0]  msg_addr;
    logic [4:0]  msg_data;
    logic        clear_req;
    logic        frame_tick;
    logic        busy;
    logic [4:0]  letter;
    logic [12:0] pixel;
    logic        valid;

    always #5 clk = ~clk;

    text_banner_renderer dut (
        .clk(clk), .reset(reset), .row(row), .col(col),
        .msg_we(msg_we), .msg_addr(msg_addr), .msg_data(msg_data),
        .clear_req(clear_req), .frame_tick(frame_tick),
        .busy(busy), .letter(letter), .pixel(pixel), .valid(valid)
    );

    typedef struct packed {
        logic [4:0]  l;
        logic [12:0] p;
        logic        v;
    } exp_t;

    exp_t       exp_q[$];
    logic [4:0] mem_m [12];
    bit         blink_on_m = 1'b1;
    int         errors = 0;
    int         checks = 0;
    int         n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int l, input int p, input bit v);
        exp_t e;
        e.l = 5'(l);
        e.p = 13'(p);
        e.v = v;
        return e;
    endfunction

    function automatic exp_t model(input int r, input int c);
        exp_t e;
        int rx, ry;
        e = mk(31, 0, 1'b0);
        if (c >= 170 && c < 370 && r >= 190 && r < 340) begin
            rx  = c - 170;
            ry  = r - 190;
            e.l = mem_m[(ry / 50) * 4 + rx / 50];
            e.p = 13'((ry % 50) * 50 + rx % 50);
            e.v = (e.l != 5'd31) && blink_on_m;
        end
        return e;
    endfunction

    // Called at a negedge; inputs change after the first edge so latency is pinned to exactly 2.
    task automatic scan(input string tag, input int r, input int c, input exp_t e,
                        input bit we = 1'b0, input int wa = 0, input int wd = 0);
        exp_t got;
        row = 9'(r); col = 10'(c);
        msg_we = we; msg_addr = 4'(wa); msg_data = 5'(wd);
        exp_q.push_back(e);
        @(posedge clk); #1;
        row = '0; col = '0; msg_we = 1'b0;
        @(posedge clk); #1;
        got = exp_q.pop_front();
        chk({tag, ".letter"}, 32'(letter), 32'(got.l));
        chk({tag, ".pixel"},  32'(pixel),  32'(got.p));
        chk({tag, ".valid"},  32'(valid),  32'(got.v));
        @(negedge clk);
    endtask

    task automatic wr(input int a, input int d);
        msg_we = 1'b1; msg_addr = 4'(a); msg_data = 5'(d);
        @(negedge clk);
        msg_we = 1'b0;
        if (a < 12) mem_m[a] = 5'(d);
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    // Counts negedge samples with busy high; optionally fires clear_req plus a write mid-clear.
    task automatic count_busy(input bit pulse, output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (pulse && cnt == 5) begin
                clear_req = 1'b1; msg_we = 1'b1; msg_addr = 4'd0; msg_data = 5'd9;
            end else begin
                clear_req = 1'b0; msg_we = 1'b0;
            end
            @(negedge clk);
        end
        clear_req = 1'b0; msg_we = 1'b0;
    endtask

    task automatic scan_all(input string tag);
        for (int i = 0; i < 12; i++)
            scan(tag, 190 + (i / 4) * 50 + 7, 170 + (i % 4) * 50 + 3,
                 model(190 + (i / 4) * 50 + 7, 170 + (i % 4) * 50 + 3));
    endtask

    task automatic blank_model();
        for (int i = 0; i < 12; i++) mem_m[i] = 5'd31;
    endtask

    initial begin
        reset = 1'b1; row = '0; col = '0; msg_we = 1'b0; msg_addr = '0;
        msg_data = '0; clear_req = 1'b0; frame_tick = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset.letter", 32'(letter), 32'd31);
        chk("reset.pixel",  32'(pixel),  32'd0);
        chk("reset.valid",  32'(valid),  32'd0);
        chk("reset.busy",   32'(busy),   32'd1);
        count_busy(1'b0, n);
        chk("post_reset_busy_cycles", 32'(n), 32'd12);
        blank_model();
        scan("blank_origin", 190, 170, mk(31, 0, 1'b0));
        scan("blank_inner", 300, 350, model(300, 350));

        wr(0, 19); wr(1, 8); wr(2, 12); wr(3, 4);
        scan("t_origin", 190, 170, mk(19, 0, 1'b1));
        scan("t_corner", 239, 219, mk(19, 2499, 1'b1));
        scan("e_cell3", 190, 320, mk(4, 0, 1'b1));

        wr(6, 18);
        scan("s_cell6", 240, 270, mk(18, 0, 1'b1));
        scan("s_inner", 265, 283, mk(18, 1263, 1'b1));

        scan("above_grid", 189, 170, mk(31, 0, 1'b0));
        scan("below_grid", 340, 200, mk(31, 0, 1'b0));
        scan("right_of_grid", 190, 370, mk(31, 0, 1'b0));
        scan("last_col", 190, 369, mk(4, 49, 1'b1));
        scan("last_row", 339, 170, mk(31, 2450, 1'b0));
        wr(12, 0);
        scan_all("grid_after_oob_wr");

        scan("same_cycle_wr", 240, 220, mk(31, 0, 1'b0), 1'b1, 5, 2);
        mem_m[5] = 5'd2;
        scan("next_cycle_rd", 240, 220, mk(2, 0, 1'b1));

        for (int i = 0; i < 16; i++) begin
            int r, c;
            r = int'($urandom_range(180, 350));
            c = int'($urandom_range(160, 380));
            scan("sweep", r, c, model(r, c));
        end

        clear_req = 1'b1; msg_we = 1'b1; msg_addr = 4'd0; msg_data = 5'd7;
        @(negedge clk);
        clear_req = 1'b0; msg_we = 1'b0;
        count_busy(1'b0, n);
        chk("clear_busy_cycles", 32'(n), 32'd12);
        blank_model();
        scan_all("after_clear");

        wr(0, 7); wr(11, 3);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        count_busy(1'b1, n);
        chk("clear_ignore_restart_cycles", 32'(n), 32'd12);
        blank_model();
        scan_all("after_clear2");

        wr(4, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        count_busy(1'b0, n);
        chk("reset_mid_clear_cycles", 32'(n), 32'd12);
        blank_model();
        scan("after_reset_clear", 240, 170, model(240, 170));

        wr(0, 19);
        scan("blink_pre", 190, 170, model(190, 170));
        ticks(29);
        scan("blink_29", 195, 180, model(195, 180));
        ticks(1);
`ifdef TEXT_BLINK_EN
        blink_on_m = 1'b0;
`endif
        scan("blink_30", 195, 180, model(195, 180));
        ticks(30);
`ifdef TEXT_BLINK_EN
        blink_on_m = 1'b1;
`endif
        scan("blink_60", 195, 180, model(195, 180));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end
endmodule
